// File: rtl/io_turnaround_arbiter_if.sv
// Request/grant and read-back bundle for io_turnaround_arbiter.
// The shared inout net itself stays a plain port on the arbiter.
interface io_turnaround_arbiter_if #(
  parameter int W = 1
);
  logic [1:0]   req;
  logic [1:0]   done;
  logic [W-1:0] wdata0;
  logic [W-1:0] wdata1;
  logic [1:0]   gnt;
  logic         busy;
  logic [W-1:0] rdata;
  logic         rvalid;
  logic         err;

  modport master (
    output req, done, wdata0, wdata1,
    input  gnt, busy, rdata, rvalid, err
  );

  modport slave (
    input  req, done, wdata0, wdata1,
    output gnt, busy, rdata, rvalid, err
  );
endinterface

// File: rtl/io_turnaround_arbiter.sv
// Round-robin owner of a shared inout net with hold limit and high-Z turnaround gaps.
// Optional contention check on the driven net: define IO_CONTENTION_CHK_EN.
module io_turnaround_arbiter #(
  parameter int W        = 1,
  parameter int TURN_CYC = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  io_turnaround_arbiter_if.slave  bus,
  inout  wire  [W-1:0]            io
);

  localparam int HW = $clog2(MAX_HOLD) + 1;
  localparam int TW = $clog2(TURN_CYC) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN  = 2'd1;
  localparam logic [1:0] TURN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          last_owner_q, last_owner_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TW-1:0] turn_cnt_q, turn_cnt_d;
  logic [W-1:0]  rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic [W-1:0]  drv_val;
  logic          owner;

  // Both requesting: the one that did not own last. Otherwise the sole requester.
  function automatic logic [1:0] pick(input logic [1:0] r, input logic last);
    if (r == 2'b11) return last ? 2'b01 : 2'b10;
    return r;
  endfunction

  assign owner   = gnt_q[1];
  assign drv_val = gnt_q[1] ? bus.wdata1 : bus.wdata0;
  assign io      = (gnt_q != 2'b00) ? drv_val : {W{1'bz}};

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    turn_cnt_d   = turn_cnt_q;
    rdata_d      = io;
    rvalid_d     = (gnt_q == 2'b00);
    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          gnt_d      = pick(bus.req, last_owner_q);
          hold_cnt_d = HW'(1);
          state_d    = OWN;
        end
      end
      OWN: begin
        if (bus.done[owner] || !bus.req[owner] || hold_cnt_q == HW'(MAX_HOLD)) begin
          gnt_d        = 2'b00;
          last_owner_d = owner;
          turn_cnt_d   = TW'(1);
          state_d      = TURN;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      TURN: begin
        if (turn_cnt_q == TW'(TURN_CYC)) begin
          if (bus.req != 2'b00) begin
            gnt_d      = pick(bus.req, last_owner_q);
            hold_cnt_d = HW'(1);
            state_d    = OWN;
          end else begin
            state_d = IDLE;
          end
        end else begin
          turn_cnt_d = turn_cnt_q + TW'(1);
        end
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  // Async reset drops gnt at once, which releases io in the same timestep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= 2'b00;
      last_owner_q <= 1'b1;
      hold_cnt_q   <= '0;
      turn_cnt_q   <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      turn_cnt_q   <= turn_cnt_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;

`ifdef IO_CONTENTION_CHK_EN
  logic err_q, err_d;

  // X or Z on a net we drive also counts as contention, hence the case inequality.
  always_comb begin
    err_d = err_q;
    if (gnt_q != 2'b00 && io !== drv_val) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_io_turnaround_arbiter.sv
// Directed bench for io_turnaround_arbiter; expected values are hand-derived per cycle.
module tb_io_turnaround_arbiter;

  localparam int W        = 1;
  localparam int TURN_CYC = 2;
  localparam int MAX_HOLD = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  wire  [W-1:0] io;
  logic         ext_en;
  logic [W-1:0] ext_val;
  int           checks = 0;
  int           errors = 0;

  io_turnaround_arbiter_if #(.W(W)) bus ();

  io_turnaround_arbiter #(.W(W), .TURN_CYC(TURN_CYC), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .io    (io)
  );

  // Stand-in for the external pad driver.
  assign io = ext_en ? ext_val : {W{1'bz}};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] d);
    bus.req  = r;
    bus.done = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    ext_en     = 1'b0;
    ext_val    = '0;
    bus.wdata0 = 1'b1;
    bus.wdata1 = 1'b0;
    applyStimulus(2'b00, 2'b00);
    repeat (2) @(negedge clk);

    checkOutput("rst_gnt",    32'(bus.gnt),    0);
    checkOutput("rst_busy",   32'(bus.busy),   0);
    checkOutput("rst_rdata",  32'(bus.rdata),  0);
    checkOutput("rst_rvalid", 32'(bus.rvalid), 0);
    checkOutput("rst_err",    32'(bus.err),    0);
    rst_n = 1'b1;

    // Single requester for three sampled cycles
    applyStimulus(2'b01, 2'b00);
    step();
    checkOutput("single_gnt1",   32'(bus.gnt),    1);
    checkOutput("single_io1",    32'(io),         1);
    checkOutput("single_rv1",    32'(bus.rvalid), 1);
    step();
    checkOutput("single_gnt2",   32'(bus.gnt),    1);
    checkOutput("single_rdata2", 32'(bus.rdata),  1);
    checkOutput("single_rv2",    32'(bus.rvalid), 0);
    step();
    checkOutput("single_gnt3",   32'(bus.gnt),    1);
    applyStimulus(2'b00, 2'b00);
    step();
    checkOutput("single_rel_gnt",  32'(bus.gnt),    0);
    checkOutput("single_rel_busy", 32'(bus.busy),   1);
    checkOutput("single_rel_rv",   32'(bus.rvalid), 0);
    step();
    checkOutput("single_turn_gnt",  32'(bus.gnt),    0);
    checkOutput("single_turn_busy", 32'(bus.busy),   1);
    checkOutput("single_turn_rv",   32'(bus.rvalid), 1);
    step();
    checkOutput("single_idle_busy", 32'(bus.busy), 0);

    // Fresh reset so requester 0 wins the first round-robin slot
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    applyStimulus(2'b11, 2'b00);
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < MAX_HOLD; c++) begin
        step();
        checkOutput($sformatf("rr_t%0d_c%0d", t, c), 32'(bus.gnt), (t % 2 == 0) ? 1 : 2);
      end
      for (int z = 0; z < TURN_CYC; z++) begin
        step();
        checkOutput($sformatf("rr_t%0d_z%0d", t, z), 32'(bus.gnt), 0);
      end
    end

    // Requester 1 releases early with done in its third owned cycle
    step();
    checkOutput("early_own1", 32'(bus.gnt), 2);
    step();
    checkOutput("early_own2", 32'(bus.gnt), 2);
    step();
    checkOutput("early_own3", 32'(bus.gnt), 2);
    applyStimulus(2'b11, 2'b10);
    step();
    checkOutput("early_rel", 32'(bus.gnt), 0);
    applyStimulus(2'b11, 2'b00);
    step();
    checkOutput("early_z2", 32'(bus.gnt), 0);
    step();
    checkOutput("early_regrant", 32'(bus.gnt), 1);

    // Hand the bus to requester 1, then reset mid-grant
    bus.wdata1 = 1'b1;
    applyStimulus(2'b10, 2'b00);
    step();
    checkOutput("mid_rel", 32'(bus.gnt), 0);
    step();
    step();
    checkOutput("mid_gnt", 32'(bus.gnt), 2);
    checkOutput("mid_io",  32'(io),      1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_gnt",    32'(bus.gnt),    0);
    checkOutput("async_rvalid", 32'(bus.rvalid), 0);
    checkOutput("async_busy",   32'(bus.busy),   0);
    checkOutput("async_io_rel", 32'(io === 1'b1), 0);
    applyStimulus(2'b11, 2'b00);
    #1;
    rst_n = 1'b1;
    step();
    checkOutput("post_rst_gnt", 32'(bus.gnt), 1);

    // External driver owns the net while the arbiter is idle
    applyStimulus(2'b00, 2'b00);
    repeat (3) step();
    checkOutput("ext_idle", 32'(bus.busy), 0);
    ext_en  = 1'b1;
    ext_val = 1'b0;
    step();
    checkOutput("ext_rdata0", 32'(bus.rdata),  0);
    checkOutput("ext_rv0",    32'(bus.rvalid), 1);
    ext_val = 1'b1;
    step();
    checkOutput("ext_rdata1", 32'(bus.rdata),  1);
    checkOutput("ext_rv1",    32'(bus.rvalid), 1);
    ext_val = 1'b0;
    step();
    checkOutput("ext_rdata2", 32'(bus.rdata),  0);
    checkOutput("ext_rv2",    32'(bus.rvalid), 1);
    ext_en = 1'b0;

`ifdef IO_CONTENTION_CHK_EN
    bus.wdata0 = 1'b1;
    applyStimulus(2'b01, 2'b00);
    step();
    checkOutput("cont_gnt", 32'(bus.gnt), 1);
    checkOutput("cont_err_before", 32'(bus.err), 0);
    force io = 1'b0;
    step();
    checkOutput("cont_err_set", 32'(bus.err), 1);
    release io;
    applyStimulus(2'b00, 2'b00);
    repeat (3) step();
    checkOutput("cont_err_sticky", 32'(bus.err), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("cont_err_rst", 32'(bus.err), 0);
    rst_n = 1'b1;
`else
    checkOutput("err_tied_low", 32'(bus.err), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
